// File: rtl/filter_sample_ctrl.sv
// filter_sample_ctrl: sample-period tick generator and trigger/capture sequencer for an SOS filter,
// with sticky overrun/timeout flags and a saturating dropped-tick counter.
module filter_sample_ctrl #(
    parameter int DATA_SIZE = 24,
    parameter int DIV_WIDTH = 16,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 clear_flags,
    input  logic [DATA_SIZE-1:0] src_data,
    output logic [DATA_SIZE-1:0] filt_data_in,
    output logic                 sample_trig,
    input  logic [DATA_SIZE-1:0] filt_data_out,
    input  logic                 filter_done,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout_err,
    output logic [7:0]           drop_count
);
    localparam int WW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, TRIG, WAIT, CAPTURE} state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, per_q, per_d;
    logic [WW-1:0]        wcnt_q, wcnt_d;
    logic [DATA_SIZE-1:0] fdi_q, fdi_d, od_q, od_d;
    logic                 ov_q, ov_d, tmo_q, tmo_d;
    logic [7:0]           drop_q, drop_d, drop_base;
    logic                 tick, tmo_set, drop_evt;

    // Period limit is latched at the start of each period so mid-period div_value changes wait a period.
    always_comb begin
        tick  = enable && cnt_q != '0 && cnt_q == per_q;
        cnt_d = (!enable || tick) ? '0 : cnt_q + 1'b1;
        per_d = (cnt_q == '0) ? ((div_value < 3) ? DIV_WIDTH'(3) : div_value) : per_q;
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        fdi_d   = fdi_q;
        od_d    = od_q;
        tmo_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    fdi_d   = src_data;
                    state_d = TRIG;
                end
            end
            TRIG: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (filter_done) begin
                    od_d    = filt_data_out;
                    state_d = CAPTURE;
                end else if (wcnt_q == WW'(TIMEOUT)) begin
                    tmo_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new event in the same cycle as clear_flags wins over the clear.
    always_comb begin
        drop_evt  = tick && state_q != IDLE;
        ov_d      = drop_evt || (ov_q && !clear_flags);
        tmo_d     = tmo_set || (tmo_q && !clear_flags);
        drop_base = clear_flags ? 8'd0 : drop_q;
        drop_d    = (drop_evt && drop_base != 8'hFF) ? drop_base + 8'd1 : drop_base;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            wcnt_q  <= '0;
            fdi_q   <= '0;
            od_q    <= '0;
            ov_q    <= 1'b0;
            tmo_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            wcnt_q  <= wcnt_d;
            fdi_q   <= fdi_d;
            od_q    <= od_d;
            ov_q    <= ov_d;
            tmo_q   <= tmo_d;
            drop_q  <= drop_d;
        end
    end

    assign sample_trig  = state_q == TRIG && !reset;
    assign out_valid    = state_q == CAPTURE && !reset;
    assign busy         = state_q != IDLE;
    assign filt_data_in = fdi_q;
    assign out_data     = od_q;
    assign overrun      = ov_q;
    assign timeout_err  = tmo_q;
    assign drop_count   = drop_q;
endmodule

// File: tb/tb_filter_sample_ctrl.sv
// tb_filter_sample_ctrl: randomized scoreboard bench; a transaction-level model predicts trigger and
// capture events per cycle, and a negedge monitor compares them against the DUT.
module tb_filter_sample_ctrl;
    localparam int DW  = 24;
    localparam int TMO = 1023;

    typedef struct { int cyc; logic [DW-1:0] d; } ev_t;
    typedef struct { int lo; int hi; logic [DW-1:0] d; } win_t;

    logic          clk = 1'b0, reset = 1'b1, enable = 1'b0, clear_flags = 1'b0, filter_done = 1'b0;
    logic [15:0]   div_value = 16'd9;
    logic [DW-1:0] src_data = '0, filt_data_out = '0;
    logic [DW-1:0] filt_data_in, out_data;
    logic          sample_trig, out_valid, busy, overrun, timeout_err;
    logic [7:0]    drop_count;

    filter_sample_ctrl #(.DATA_SIZE(DW), .DIV_WIDTH(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .div_value(div_value),
        .clear_flags(clear_flags), .src_data(src_data), .filt_data_in(filt_data_in),
        .sample_trig(sample_trig), .filt_data_out(filt_data_out), .filter_done(filter_done),
        .out_data(out_data), .out_valid(out_valid), .busy(busy), .overrun(overrun),
        .timeout_err(timeout_err), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int   cyc = 0, errors = 0, checks = 0, n_valid = 0;
    ev_t  trig_q[$], val_q[$];
    win_t win_q[$];
    int   run_len = 0, free_at = 0, last_acc = 0, tmo_at = -1, acc_cnt = 0;
    int   lat_lo = 4, lat_hi = 4, hold_lo = 1, hold_hi = 1;
    bit   src_fix = 1'b1, resp_fix = 1'b1, started = 1'b0, rst_seen = 1'b0;
    logic cur_ov = 0, nxt_ov = 0, cur_tmo = 0, nxt_tmo = 0, exp_busy = 0;
    logic [7:0]    cur_drop = 0, nxt_drop = 0;
    logic [DW-1:0] exp_fdi = '0, exp_od = '0;
    logic          et, ev;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model for one cycle: ticks fall every P enabled cycles, a tick is accepted only when the
    // previous transaction is fully over, and each accepted tick schedules its trigger, done window and capture.
    task automatic model_cycle();
        int p, l, h;
        logic [DW-1:0] d;
        cur_ov = nxt_ov; cur_tmo = nxt_tmo; cur_drop = nxt_drop;
        src_data = src_fix ? 24'h000100 : 24'($urandom);
        while (win_q.size() > 0 && win_q[0].hi < cyc) void'(win_q.pop_front());
        filter_done = win_q.size() > 0 && win_q[0].lo <= cyc;
        filt_data_out = filter_done ? win_q[0].d : 24'($urandom);
        exp_busy = cyc > last_acc && cyc < free_at;
        if (reset) begin
            run_len = 0; nxt_ov = 0; nxt_tmo = 0; nxt_drop = 0;
            free_at = cyc + 1; tmo_at = -1;
            trig_q.delete(); val_q.delete();
        end else begin
            run_len = enable ? run_len + 1 : 0;
            p = ((div_value < 16'd3) ? 3 : int'(div_value)) + 1;
            if (clear_flags) begin nxt_ov = 0; nxt_tmo = 0; nxt_drop = 0; end
            if (cyc == tmo_at) nxt_tmo = 1;
            if (enable && run_len % p == 0) begin
                if (cyc < free_at) begin
                    nxt_ov = 1;
                    if (nxt_drop != 8'd255) nxt_drop = nxt_drop + 8'd1;
                end else begin
                    l = (lat_lo == 0) ? 0 : int'($urandom_range(lat_hi, lat_lo));
                    h = int'($urandom_range(hold_hi, hold_lo));
                    d = resp_fix ? 24'h0000AB : 24'($urandom);
                    trig_q.push_back('{cyc + 1, src_data});
                    last_acc = cyc;
                    acc_cnt++;
                    if (l >= 1 && l <= TMO + 1) begin
                        val_q.push_back('{cyc + 2 + l, d});
                        free_at = cyc + 3 + l;
                    end else begin
                        tmo_at  = cyc + 2 + TMO;
                        free_at = cyc + 3 + TMO;
                    end
                    if (l > 0) win_q.push_back('{cyc + 1 + l, cyc + l + h, d});
                end
            end
        end
    endtask

    task automatic run(int n);
        repeat (n) begin
            model_cycle();
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic wait_accept();
        int a, n;
        a = acc_cnt; n = 0;
        while (acc_cnt == a && n < 3000) begin run(1); n++; end
        chk("accept_bound", 64'(acc_cnt != a), 1);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1; run(1); clear_flags = 1'b0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_trig"}, sample_trig, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_timeout"}, timeout_err, 0);
        chk({tag, "_drops"}, drop_count, 0);
        chk({tag, "_fdi"}, filt_data_in, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (rst_seen) begin exp_fdi = '0; exp_od = '0; end
            et = trig_q.size() > 0 && trig_q[0].cyc == cyc;
            chk("sample_trig", sample_trig, et);
            if (et) begin exp_fdi = trig_q[0].d; void'(trig_q.pop_front()); end
            chk("filt_data_in", filt_data_in, exp_fdi);
            ev = val_q.size() > 0 && val_q[0].cyc == cyc;
            chk("out_valid", out_valid, ev);
            if (ev) begin exp_od = val_q[0].d; void'(val_q.pop_front()); end
            chk("out_data", out_data, exp_od);
            chk("overrun", overrun, cur_ov);
            chk("timeout_err", timeout_err, cur_tmo);
            chk("drop_count", drop_count, cur_drop);
            chk("busy", busy, exp_busy);
            if (out_valid === 1'b1) n_valid++;
        end
        rst_seen = reset;
    end

    initial begin
        int a0, v0;
        reset = 1'b1; run(3); reset = 1'b0; started = 1'b1;
        chk_zero("reset");

        div_value = 16'd9; enable = 1'b1; run(300);
        chk("nominal_overrun", overrun, 0);
        enable = 1'b0; run(20);

        div_value = 16'd0; lat_lo = 1; lat_hi = 1; enable = 1'b1; run(200);
        chk("clamp_overrun", overrun, 0);
        enable = 1'b0; run(10);

        src_fix = 1'b0; resp_fix = 1'b0;
        div_value = 16'd5; lat_lo = 12; lat_hi = 12; enable = 1'b1; run(2300);
        chk("overrun_set", overrun, 1);
        chk("drop_saturated", drop_count, 8'd255);
        enable = 1'b0; run(20); pulse_clear();
        chk("clear_drops", drop_count, 0);
        chk("clear_overrun", overrun, 0);
        enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            clear_flags = ($urandom_range(15, 0) == 0); run(1);
        end
        clear_flags = 1'b0; enable = 1'b0; run(20); pulse_clear();

        div_value = 16'd99; lat_lo = 0; enable = 1'b1; wait_accept();
        lat_lo = 3; lat_hi = 3; run(1100);
        chk("timeout_set", timeout_err, 1);
        enable = 1'b0; run(20); pulse_clear();

        div_value = 16'd1999; lat_lo = 1024; lat_hi = 1024; enable = 1'b1; wait_accept();
        lat_lo = 1025; lat_hi = 1025; wait_accept();
        chk("timeout_edge_capture", timeout_err, 0);
        run(1100);
        chk("timeout_edge_abort", timeout_err, 1);
        enable = 1'b0; run(20); pulse_clear();

        div_value = 16'd9; lat_lo = 4; lat_hi = 4; enable = 1'b1; wait_accept();
        v0 = n_valid; run(2); enable = 1'b0; run(40);
        chk("enable_drop_valids", n_valid - v0, 1);

        enable = 1'b1; lat_lo = 8; lat_hi = 8; wait_accept();
        run(3); v0 = n_valid; reset = 1'b1; run(1); reset = 1'b0; enable = 1'b0;
        chk_zero("midreset");
        run(30);
        chk("midreset_late_done", n_valid - v0, 0);

        div_value = 16'd19; lat_lo = 4; lat_hi = 4; hold_lo = 6; hold_hi = 6;
        a0 = acc_cnt; v0 = n_valid; enable = 1'b1; run(200); enable = 1'b0; run(30);
        chk("level_done_one_capture", n_valid - v0, acc_cnt - a0);

        hold_lo = 1; hold_hi = 3; lat_lo = 1;
        for (int s = 0; s < 20; s++) begin
            div_value = 16'($urandom_range(15, 0));
            lat_hi = int'($urandom_range(14, 1));
            enable = 1'b1;
            repeat ($urandom_range(150, 50)) begin
                clear_flags = ($urandom_range(31, 0) == 0); run(1);
            end
            clear_flags = 1'b0; enable = 1'b0;
            run(int'($urandom_range(6, 1)));
        end
        run(100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
